// File: rtl/shiftadd_mult.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// N iterations per multiply, result held on P until the next completed multiply.
module shiftadd_mult #(
  parameter int N = 512
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N:0]   P,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2*N:0]    r_a;
  logic [N-1:0]    r_b;
  logic [2*N:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [2*N:0]    r_p;
  logic            r_done;
  logic            w_last;

  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = r_done;
    P    = r_p;
  end

  // A is walked left and B right each iteration, so the add always sees
  // A<<i gated by B[i] without a wide barrel shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_p    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= {{(N + 1){1'b0}}, A};
            r_b   <= B;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
        S_DONE: begin
          r_p    <= r_acc;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult.sv
// Directed bench for shiftadd_mult: latency, busy/done framing, operand
// capture, abort/ignore behaviour, reset mid-run and back-to-back starts.
module tb_shiftadd_mult;

  localparam int N = 512;
  localparam int W = 2 * N + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [W-1:0]   P;
  logic           busy;
  logic           done;

  int n_chk;
  int n_pass;

  shiftadd_mult #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
               tag, obs[W-1:W-129], obs[127:0], exp[W-1:W-129], exp[127:0]);
    end
  endtask

  // Starts one multiply and watches it to completion. pulse_at >= 0 re-pulses
  // start (with different operands) so that it lands on edge k+pulse_at+1.
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [W-1:0] exp_p, input int pulse_at,
                          input string tag);
    logic [W-1:0] prev_p;
    int busy_cnt, done_cnt, done_at, p_changed, both;
    busy_cnt = 0; done_cnt = 0; done_at = -1; p_changed = 0; both = 0;
    prev_p = P;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a ^ N'($urandom);
    B = ~b;
    for (int j = 0; j < N + 4; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j == pulse_at) begin
        start = 1'b1; A = N'(2); B = N'(2);
      end else if (j == pulse_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (busy && done) both++;
      if (j <= N && P !== prev_p) p_changed++;
    end
    chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(N));
    chk({tag, "_done_latency"}, W'(done_at), W'(N + 1));
    chk({tag, "_done_count"}, W'(done_cnt), W'(1));
    chk({tag, "_busy_and_done"}, W'(both), W'(0));
    chk({tag, "_p_held_in_run"}, W'(p_changed), W'(0));
    chk({tag, "_product"}, P, exp_p);
    chk({tag, "_p_msb"}, W'(P[W-1]), W'(0));
  endtask

  initial begin
    logic [N-1:0] all1;
    logic [N-1:0] half;
    logic [W-1:0] exp_max;
    logic [N-1:0] ba [3];
    logic [N-1:0] bb [3];
    logic [W-1:0] bexp [3];
    int idx, last_done, exp_c, seen_done;

    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b1; A = N'(3); B = N'(5);
    #1;
    chk("reset_p", P, W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("start_ignored_in_reset", W'(busy), W'(0));
    rst = 1'b0;

    run_mult(N'(3), N'(5), W'(15), -1, "mul3x5");

    run_mult(N'(7), N'(9), W'(63), 99, "restart_ignored");

    // Reset asserted between clock edges in the middle of a multiply
    A = N'(11); B = N'(13); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrun_rst_p", P, W'(0));
    chk("midrun_rst_busy", W'(busy), W'(0));
    chk("midrun_rst_done", W'(done), W'(0));
    seen_done = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("midrun_rst_quiet", W'(seen_done), W'(0));
    rst = 1'b0;
    run_mult(N'(11), N'(13), W'(143), -1, "after_reset");

    all1 = '1;
    exp_max = (W'(1) << (2 * N)) - (W'(1) << (N + 1)) + W'(1);
    run_mult(all1, all1, exp_max, -1, "max");
    chk("max_divides_by_m", P % W'(all1), W'(0));

    half = '0;
    half[N-1] = 1'b1;
    run_mult(N'(0), half, W'(0), -1, "zero_a");
    run_mult(half, N'(0), W'(0), -1, "zero_b");

    // Back-to-back with start held high; operands change only at each done
    ba[0] = N'(5);    bb[0] = N'(6);    bexp[0] = W'(30);
    ba[1] = N'(1000); bb[1] = N'(1000); bexp[1] = W'(1000000);
    ba[2] = all1;     bb[2] = N'(2);    bexp[2] = (W'(1) << (N + 1)) - W'(2);
    idx = 0; last_done = -1;
    A = ba[0]; B = bb[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3 * N + 10; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (done) begin
        if (idx < 3) begin
          chk($sformatf("b2b_product_%0d", idx), P, bexp[idx]);
          exp_c = (idx == 0) ? (N + 1) : (last_done + N + 2);
          chk($sformatf("b2b_timing_%0d", idx), W'(c), W'(exp_c));
          last_done = c;
          idx++;
          if (idx < 3) begin
            A = ba[idx]; B = bb[idx];
          end else begin
            start = 1'b0;
          end
        end else begin
          idx++;
        end
      end
    end
    chk("b2b_done_count", W'(idx), W'(3));
    chk("b2b_idle_after", W'(busy), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
